// File: rtl/pow_sq_mul_if.sv
// Handshake and operand/result bundle for the square-and-multiply exponentiation engine.
interface pow_sq_mul_if #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     x;
    logic [EXP_WIDTH-1:0] n;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     res;
    logic                 ovf;

    modport master (
        output start, x, n,
        input  busy, done, res, ovf
    );

    modport slave (
        input  start, x, n,
        output busy, done, res, ovf
    );
endinterface

// File: rtl/pow_sq_mul.sv
// Sequential x^n mod 2^WIDTH, right-to-left square-and-multiply, one exponent bit per cycle.
//
// state | meaning
// IDLE  | waiting for start; res/ovf hold the last result
// STEP  | consume one exponent bit per cycle; leave when exponent is exhausted
// DONE  | one-cycle done pulse, then back to IDLE
module pow_sq_mul #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    pow_sq_mul_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     base, base_nxt;
    logic [WIDTH-1:0]     acc, acc_nxt;
    logic [EXP_WIDTH-1:0] e, e_nxt;
    logic                 ovf_acc, ovf_acc_nxt;
    logic [WIDTH-1:0]     res_q, res_nxt;
    logic                 ovf_q, ovf_nxt;

    logic [2*WIDTH-1:0]   mul_acc;
    logic [2*WIDTH-1:0]   mul_sq;
    logic [EXP_WIDTH-1:0] e_shr;

    assign mul_acc = {{WIDTH{1'b0}}, acc}  * {{WIDTH{1'b0}}, base};
    assign mul_sq  = {{WIDTH{1'b0}}, base} * {{WIDTH{1'b0}}, base};
    assign e_shr   = e >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            res_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            res_q <= res_nxt;
            ovf_q <= ovf_nxt;
        end
    end

    // Datapath contents are only meaningful once IDLE has loaded them.
    always_ff @(posedge clk) begin
        base    <= base_nxt;
        acc     <= acc_nxt;
        e       <= e_nxt;
        ovf_acc <= ovf_acc_nxt;
    end

    always_comb begin
        state_nxt   = state;
        base_nxt    = base;
        acc_nxt     = acc;
        e_nxt       = e;
        ovf_acc_nxt = ovf_acc;
        res_nxt     = res_q;
        ovf_nxt     = ovf_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    base_nxt    = bus.x;
                    e_nxt       = bus.n;
                    acc_nxt     = WIDTH'(1);
                    ovf_acc_nxt = 1'b0;
                    state_nxt   = STEP;
                end
            end
            STEP: begin
                if (e != '0) begin
                    if (e[0]) begin
                        acc_nxt = mul_acc[WIDTH-1:0];
                        if (|mul_acc[2*WIDTH-1:WIDTH]) ovf_acc_nxt = 1'b1;
                    end
                    // A squared base that overflows only matters if a later bit will use it.
                    base_nxt = mul_sq[WIDTH-1:0];
                    if ((|mul_sq[2*WIDTH-1:WIDTH]) && (e_shr != '0)) ovf_acc_nxt = 1'b1;
                    e_nxt = e_shr;
                end else begin
                    res_nxt   = acc;
                    ovf_nxt   = ovf_acc;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = (state == STEP);
    assign bus.done = (state == DONE);
    assign bus.res  = res_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_pow_sq_mul.sv
// Directed bench for pow_sq_mul: 32-bit and 8-bit/4-bit-exponent instances.
module tb_pow_sq_mul;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;

    pow_sq_mul_if #(.WIDTH(32), .EXP_WIDTH(32)) b32 ();
    pow_sq_mul_if #(.WIDTH(8),  .EXP_WIDTH(4))  b8 ();

    pow_sq_mul #(.WIDTH(32), .EXP_WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    pow_sq_mul #(.WIDTH(8),  .EXP_WIDTH(4))  dut8  (.clk(clk), .rst(rst), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Launch one operation; lat = edges from acceptance to the done cycle (-1 on timeout).
    // poke > 0 drives a spurious start in that cycle while the op runs.
    task automatic run32(input logic [31:0] xv, input logic [31:0] nv, input int poke,
                         output int lat, output int busy_cnt, output logic [31:0] res_early,
                         output int t_acc);
        lat = -1;
        busy_cnt = 0;
        @(negedge clk);
        b32.start = 1'b1;
        b32.x = xv;
        b32.n = nv;
        @(negedge clk);
        b32.start = 1'b0;
        t_acc = cyc;
        res_early = b32.res;
        for (int k = 1; k <= 100; k++) begin
            if (b32.busy) busy_cnt++;
            if (b32.done) begin
                lat = k - 1;
                break;
            end
            if (k == poke) begin
                b32.start = 1'b1;
                b32.x = 32'd9;
                b32.n = 32'd2;
            end else begin
                b32.start = 1'b0;
            end
            @(negedge clk);
        end
        b32.start = 1'b0;
    endtask

    task automatic run8(input logic [7:0] xv, input logic [3:0] nv, output int lat);
        lat = -1;
        @(negedge clk);
        b8.start = 1'b1;
        b8.x = xv;
        b8.n = nv;
        @(negedge clk);
        b8.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (b8.done) begin
                lat = k - 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({b32.busy, b32.done, b32.ovf} !== 3'b000 || b32.res !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b res=%h ovf=%b, want all zero",
                     b32.busy, b32.done, b32.res, b32.ovf);
        end
        n_checks++;
        if ({b8.busy, b8.done, b8.ovf} !== 3'b000 || b8.res !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state8: busy=%b done=%b res=%h ovf=%b, want all zero",
                     b8.busy, b8.done, b8.res, b8.ovf);
        end
    endtask

    task automatic test_basic();
        int lat, bc, ta;
        logic [31:0] re;
        run32(32'd3, 32'd5, 0, lat, bc, re, ta);
        n_checks++;
        if (lat !== 4 || bc !== 4) begin
            n_fail++;
            $display("FAIL basic_timing: lat=%0d busy=%0d, want lat=4 busy=4", lat, bc);
        end
        n_checks++;
        if (b32.res !== 32'd243 || b32.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_3p5: res=%0d ovf=%b, want 243 ovf=0", b32.res, b32.ovf);
        end
        @(negedge clk);
        n_checks++;
        if (b32.done !== 1'b0 || b32.res !== 32'd243) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b res=%0d, want done=0 res=243", b32.done, b32.res);
        end
    endtask

    task automatic test_zero_exp();
        int lat, bc, ta;
        logic [31:0] re;
        logic [31:0] xs [2] = '{32'd7, 32'd0};
        for (int i = 0; i < 2; i++) begin
            run32(xs[i], 32'd0, 0, lat, bc, re, ta);
            n_checks++;
            if (lat !== 1 || b32.res !== 32'd1 || b32.ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_exp x=%0d: lat=%0d res=%0d ovf=%b, want lat=1 res=1 ovf=0",
                         xs[i], lat, b32.res, b32.ovf);
            end
        end
        run32(32'd0, 32'd9, 0, lat, bc, re, ta);
        n_checks++;
        if (lat !== 5 || b32.res !== 32'd0 || b32.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_base: lat=%0d res=%0d ovf=%b, want lat=5 res=0 ovf=0",
                     lat, b32.res, b32.ovf);
        end
    endtask

    task automatic test_overflow();
        int lat, bc, ta;
        logic [31:0] re;
        logic [31:0] xs   [3] = '{32'd2, 32'd2, 32'd65536};
        logic [31:0] ns   [3] = '{32'd31, 32'd32, 32'd1};
        logic [31:0] rexp [3] = '{32'h8000_0000, 32'd0, 32'd65536};
        logic        oexp [3] = '{1'b0, 1'b1, 1'b0};
        int          lexp [3] = '{6, 7, 2};
        for (int i = 0; i < 3; i++) begin
            run32(xs[i], ns[i], 0, lat, bc, re, ta);
            n_checks++;
            if (lat !== lexp[i] || b32.res !== rexp[i] || b32.ovf !== oexp[i]) begin
                n_fail++;
                $display("FAIL overflow x=%0d n=%0d: lat=%0d res=%h ovf=%b, want lat=%0d res=%h ovf=%b",
                         xs[i], ns[i], lat, b32.res, b32.ovf, lexp[i], rexp[i], oexp[i]);
            end
        end
    endtask

    task automatic test_long_ignore_start();
        int lat, bc, ta;
        logic [31:0] re;
        run32(32'd1, 32'hFFFF_FFFF, 5, lat, bc, re, ta);
        n_checks++;
        if (lat !== 33 || bc !== 33) begin
            n_fail++;
            $display("FAIL long_timing: lat=%0d busy=%0d, want 33/33", lat, bc);
        end
        n_checks++;
        if (b32.res !== 32'd1 || b32.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL long_result: res=%0d ovf=%b, want 1 ovf=0", b32.res, b32.ovf);
        end
        @(negedge clk);
        n_checks++;
        if (b32.busy !== 1'b0 || b32.done !== 1'b0) begin
            n_fail++;
            $display("FAIL no_queue: busy=%b done=%b after done, want 0/0", b32.busy, b32.done);
        end
    endtask

    task automatic test_abort();
        int lat, bc, ta;
        logic [31:0] re;
        bit saw_done;
        @(negedge clk);
        b32.start = 1'b1;
        b32.x = 32'd3;
        b32.n = 32'd5;
        @(negedge clk);
        b32.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (b32.busy !== 1'b0 || b32.res !== 32'd0 || b32.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b res=%0d ovf=%b, want 0/0/0", b32.busy, b32.res, b32.ovf);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (b32.done || b32.busy) saw_done = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet: activity=%b after reset, want 0", saw_done);
        end
        run32(32'd5, 32'd3, 0, lat, bc, re, ta);
        n_checks++;
        if (lat !== 3 || b32.res !== 32'd125 || b32.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL restart: lat=%0d res=%0d ovf=%b, want lat=3 res=125 ovf=0",
                     lat, b32.res, b32.ovf);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, bc, ta1, ta2;
        logic [31:0] re;
        run32(32'd3, 32'd2, 0, lat1, bc, re, ta1);
        run32(32'd2, 32'd3, 0, lat2, bc, re, ta2);
        n_checks++;
        if (re !== 32'd9) begin
            n_fail++;
            $display("FAIL res_hold: res=%0d during next op, want 9", re);
        end
        n_checks++;
        if (ta2 - ta1 !== 5 || lat2 !== 3 || b32.res !== 32'd8) begin
            n_fail++;
            $display("FAIL back_to_back: spacing=%0d lat=%0d res=%0d, want 5/3/8",
                     ta2 - ta1, lat2, b32.res);
        end
    endtask

    task automatic test_rst_start();
        bit active;
        @(negedge clk);
        rst = 1'b1;
        b32.start = 1'b1;
        b32.x = 32'd3;
        b32.n = 32'd5;
        @(negedge clk);
        rst = 1'b0;
        b32.start = 1'b0;
        active = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (b32.busy || b32.done) active = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (active !== 1'b0 || b32.res !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_wins: activity=%b res=%0d, want 0/0", active, b32.res);
        end
    endtask

    task automatic test_width8();
        int lat;
        run8(8'd3, 4'd5, lat);
        n_checks++;
        if (lat !== 4 || b8.res !== 8'd243 || b8.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL w8_3p5: lat=%0d res=%0d ovf=%b, want lat=4 res=243 ovf=0", lat, b8.res, b8.ovf);
        end
        run8(8'd3, 4'd6, lat);
        n_checks++;
        if (lat !== 4 || b8.res !== 8'hD9 || b8.ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL w8_3p6: lat=%0d res=%h ovf=%b, want lat=4 res=d9 ovf=1", lat, b8.res, b8.ovf);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        b32.start = 1'b0;
        b32.x = '0;
        b32.n = '0;
        b8.start = 1'b0;
        b8.x = '0;
        b8.n = '0;
        test_reset();
        test_basic();
        test_zero_exp();
        test_overflow();
        test_long_ignore_start();
        test_abort();
        test_back_to_back();
        test_rst_start();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
